// File: rtl/cpu_oam_dma_if.sv
// cpu_oam_dma_if -- bus bundle for the OAM DMA engine.
//
// Groups the CPU-side inputs, the DMA source-memory port and the PPU register
// interface port into one interface. Clock and reset are not carried here.
//   ce_in          CPU cycle enable
//   cpu_a_in       CPU address
//   cpu_r_nw_in    CPU read(1)/write(0)
//   cpu_d_in       CPU write data
//   mem_d_in       memory read data returned for mem_a_out
//   mem_a_out      DMA source address (zero outside READ)
//   mem_r_nw_out   memory strobe, always read
//   ri_sel_out     PPU register select
//   ri_ncs_out     PPU register chip select, active low
//   ri_r_nw_out    PPU register read(1)/write(0)
//   ri_d_out       PPU register write data
//   dma_active_out high while a transfer runs (CPU RDY low)
// master: the environment (CPU, memory, PPU side); slave: the DMA engine.
interface cpu_oam_dma_if;
  logic        ce_in;
  logic [15:0] cpu_a_in;
  logic        cpu_r_nw_in;
  logic [7:0]  cpu_d_in;
  logic [7:0]  mem_d_in;
  logic [15:0] mem_a_out;
  logic        mem_r_nw_out;
  logic [2:0]  ri_sel_out;
  logic        ri_ncs_out;
  logic        ri_r_nw_out;
  logic [7:0]  ri_d_out;
  logic        dma_active_out;

  modport master (
    output ce_in, cpu_a_in, cpu_r_nw_in, cpu_d_in, mem_d_in,
    input  mem_a_out, mem_r_nw_out, ri_sel_out, ri_ncs_out, ri_r_nw_out,
           ri_d_out, dma_active_out
  );

  modport slave (
    input  ce_in, cpu_a_in, cpu_r_nw_in, cpu_d_in, mem_d_in,
    output mem_a_out, mem_r_nw_out, ri_sel_out, ri_ncs_out, ri_r_nw_out,
           ri_d_out, dma_active_out
  );
endinterface

// File: rtl/cpu_oam_dma.sv
// cpu_oam_dma -- sprite (OAM) DMA engine.
//
// A CPU write to DMA_ADDR latches a source page and copies the 256 bytes
// {page,00}..{page,FF} from CPU memory into the PPU OAMDATA register, one
// READ/WRITE pair per byte after a single START alignment cycle. All state
// advances only on clk_in edges where ce_in is high.
// Ports:
//   clk_in  system clock
//   rst_in  synchronous active-high reset
//   bus     cpu_oam_dma_if.slave (CPU inputs, memory port, PPU register port,
//           dma_active_out)
// Every output is a register (mem_r_nw_out is a constant); no CPU input
// reaches an output combinationally.
module cpu_oam_dma #(
  parameter logic [15:0] DMA_ADDR     = 16'h4014,
  parameter logic [2:0]  OAM_DATA_SEL = 3'h4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  cpu_oam_dma_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic [7:0]  page_r;
  // Data latch; it doubles as the ri_d_out register, so it is cleared when
  // WRITE is left to keep ri_d_out at zero outside WRITE.
  logic [7:0]  data_r;
  logic [15:0] mem_a_r;
  logic [2:0]  ri_sel_r;
  logic        ri_ncs_r;
  logic        ri_r_nw_r;
  logic        dma_active_r;
  logic        trigger_s;
  logic [7:0]  cnt_next_s;

  assign trigger_s  = (bus.cpu_a_in == DMA_ADDR) && (bus.cpu_r_nw_in == 1'b0);
  // 8-bit wrap is intended: the source address never carries into the page.
  assign cnt_next_s = cnt_r + 8'd1;

  // Transfer FSM with registered outputs; each output register is loaded with
  // the value belonging to the state being entered.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'h00;
      page_r       <= 8'h00;
      data_r       <= 8'h00;
      mem_a_r      <= 16'h0000;
      ri_sel_r     <= 3'h0;
      ri_ncs_r     <= 1'b1;
      ri_r_nw_r    <= 1'b1;
      dma_active_r <= 1'b0;
    end else if (bus.ce_in) begin
      case (state_r)
        ST_IDLE: begin
          if (trigger_s) begin
            page_r       <= bus.cpu_d_in;
            cnt_r        <= 8'h00;
            dma_active_r <= 1'b1;
            state_r      <= ST_START;
          end
        end
        ST_START: begin
          mem_a_r <= {page_r, cnt_r};
          state_r <= ST_READ;
        end
        ST_READ: begin
          data_r    <= bus.mem_d_in;
          mem_a_r   <= 16'h0000;
          ri_sel_r  <= OAM_DATA_SEL;
          ri_ncs_r  <= 1'b0;
          ri_r_nw_r <= 1'b0;
          state_r   <= ST_WRITE;
        end
        ST_WRITE: begin
          data_r    <= 8'h00;
          ri_sel_r  <= 3'h0;
          ri_ncs_r  <= 1'b1;
          ri_r_nw_r <= 1'b1;
          if (cnt_r == 8'hFF) begin
            dma_active_r <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            cnt_r   <= cnt_next_s;
            mem_a_r <= {page_r, cnt_next_s};
            state_r <= ST_READ;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          cnt_r        <= 8'h00;
          data_r       <= 8'h00;
          mem_a_r      <= 16'h0000;
          ri_sel_r     <= 3'h0;
          ri_ncs_r     <= 1'b1;
          ri_r_nw_r    <= 1'b1;
          dma_active_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_a_out      = mem_a_r;
  assign bus.mem_r_nw_out   = 1'b1;
  assign bus.ri_sel_out     = ri_sel_r;
  assign bus.ri_ncs_out     = ri_ncs_r;
  assign bus.ri_r_nw_out    = ri_r_nw_r;
  assign bus.ri_d_out       = data_r;
  assign bus.dma_active_out = dma_active_r;

endmodule

// File: doc/cpu_oam_dma.md
CPU_OAM_DMA -- requirements
Module: cpu_oam_dma

Interface
REQ-001 SHALL have parameters: DMA_ADDR, 16'h4014, CPU address that triggers a transfer; OAM_DATA_SEL, 3'h4, PPU register select for OAMDATA.
REQ-002 SHALL have ports, one clock; reset is synchronous and active-high: clk_in in 1 system clock; rst_in in 1 synchronous active-high reset.
REQ-003 ports: ce_in in 1 CPU cycle enable; FSM advances only on clk_in edges with ce_in=1.
REQ-004 ports: cpu_a_in in 16 CPU address; cpu_r_nw_in in 1 CPU read(1)/write(0); cpu_d_in in 8 CPU write data.
REQ-005 ports: mem_d_in in 8 CPU memory read data, valid during READ.
REQ-006 ports: mem_a_out out 16 DMA source address; mem_r_nw_out out 1 read strobe, always 1.
REQ-007 ports: ri_sel_out out 3; ri_ncs_out out 1 (active low); ri_r_nw_out out 1; ri_d_out out 8; these drive the PPU register interface.
REQ-008 ports: dma_active_out out 1; high while a transfer is in progress, used to halt the CPU (RDY low).

Function
REQ-009 SHALL implement states IDLE, START, READ, WRITE; 8-bit byte counter cnt; 8-bit page register; 8-bit data latch.
REQ-010 Trigger: in IDLE, on ce_in=1 with cpu_a_in==DMA_ADDR and cpu_r_nw_in=0, SHALL latch page<=cpu_d_in, cnt<=0, go to START.
REQ-011 Triggers occurring outside IDLE SHALL be ignored; page SHALL stay unchanged.
REQ-012 START -> READ on ce_in=1 (one alignment cycle).
REQ-013 READ: mem_a_out={page,cnt}; on ce_in=1 SHALL latch data<=mem_d_in and go to WRITE.
REQ-014 WRITE: ri_sel_out=OAM_DATA_SEL, ri_r_nw_out=0, ri_ncs_out=0, ri_d_out=data; on ce_in=1, if cnt==8'hFF go to IDLE, else cnt<=cnt+1 and go to READ.
REQ-015 ri_ncs_out SHALL be low only in WRITE, giving one falling edge per byte; exactly 256 writes per transfer.
REQ-016 Outside WRITE: ri_ncs_out=1, ri_r_nw_out=1, ri_sel_out=0, ri_d_out=0; outside READ: mem_a_out=0.
REQ-017 dma_active_out SHALL be high in START, READ and WRITE, and low in IDLE; with ce_in held 1, it SHALL be high for exactly 513 cycles.
REQ-018 Counter arithmetic SHALL be 8-bit; source addresses SHALL span {page,00}..{page,FF} and never carry into page.
REQ-019 While ce_in=0, state, outputs, cnt and data SHALL hold.
REQ-020 Page 8'h00 and page 8'hFF SHALL be transferred identically to any other page.
REQ-021 A trigger on the same ce cycle that returns to IDLE SHALL be ignored, because the FSM is not in IDLE.
REQ-022 All outputs SHALL be registered or decoded from registered state only; no combinational path from cpu_* to outputs.

Reset
REQ-023 With rst_in=1 at a clock edge, SHALL enter IDLE with cnt=0, page=0, data=0; regardless of ce_in.
REQ-024 Reset values: dma_active_out=0, ri_ncs_out=1, ri_r_nw_out=1, ri_sel_out=0, ri_d_out=0, mem_a_out=0, mem_r_nw_out=1.
REQ-025 Reset during a transfer SHALL abort it immediately; no further ri writes; the next trigger restarts at cnt=0.

Verification
REQ-026 ce_in=1; write 8'h02 to 16'h4014; memory[16'h0200+i]=i^8'h5A -> 256 ri writes with sel=4 and data i^8'h5A in order; dma_active_out high 513 cycles.
REQ-027 ce_in pulsed every 4th clock; page 8'h07 -> same 256-byte sequence; dma_active_out high 513 ce cycles; outputs stable between enables.
REQ-028 Second write to 16'h4014 (data 8'h03) at byte 100 -> ignored; all 256 source addresses remain 16'h02xx.
REQ-029 Read (cpu_r_nw_in=1) of 16'h4014, and write to 16'h4013 -> no transfer; dma_active_out stays 0.
REQ-030 rst_in at byte 37 of page 8'hFF -> outputs at reset values the next cycle; new trigger with page 8'h01 -> writes start from 16'h0100.
REQ-031 Page 8'hFF, byte 255 -> mem_a_out=16'hFFFF, last write, then IDLE; no access to 16'h0000.
